fetch_stage: RTL and testbench

- Instruction-fetch stage with IF/ID pipeline register. Sits directly upstream of the decode/controller logic and the execute-to-memory buffer.
- Owns the PC register and drives the word address into the combinational instruction memory.
- Captures the fetched word plus PC+4 into an IF/ID register consumed by decode.
- Supports stall (hold) from hazard logic and redirect (flush) from branch/JAL resolution.

---
 rtl/fetch_stage.sv | 87 ++++++++
 tb/tb_fetch_stage.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: PC register, imem addressing and the IF/ID register.
// Optional FETCH_PERF_CNT_EN adds fetch/stall event counters.
module fetch_stage #(
  parameter int               DBITS               = 32,
  parameter logic [DBITS-1:0] START_PC            = 32'd0,
  parameter int               IMEM_ADDR_BIT_WIDTH = 11,
  parameter logic [DBITS-1:0] NOP_INST            = 32'd0
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           stall,
  input  logic                           redirect_en,
  input  logic [DBITS-1:0]               redirect_pc,
  input  logic [DBITS-1:0]               imem_data,
  output logic [IMEM_ADDR_BIT_WIDTH-1:0] imem_addr,
  output logic [DBITS-1:0]               pc_out,
  output logic [DBITS-1:0]               if_inst,
  output logic [DBITS-1:0]               if_pc_plus4,
  output logic                           if_valid
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0]                    fetch_count,
  output logic [31:0]                    stall_count
`endif
);

  localparam logic [DBITS-1:0] PC_STEP = DBITS'(4);

  function automatic logic [DBITS-1:0] align_pc(input logic [DBITS-1:0] addr);
    return {addr[DBITS-1:2], 2'b00};
  endfunction

  logic [DBITS-1:0] pc_p0;
  logic [DBITS-1:0] pc_plus4_p0;
  logic [DBITS-1:0] inst_p1;
  logic [DBITS-1:0] pc_plus4_p1;
  logic             vld_p1;

  // Stage 0: PC register and combinational instruction-memory address
  assign pc_plus4_p0 = pc_p0 + PC_STEP;
  assign imem_addr   = pc_p0[IMEM_ADDR_BIT_WIDTH+1:2];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc_p0 <= START_PC;
    end else if (redirect_en) begin
      pc_p0 <= align_pc(redirect_pc);
    end else if (!stall) begin
      pc_p0 <= pc_plus4_p0;
    end
  end

  // Stage 1: IF/ID register; a redirect discards the wrong-path word on imem_data
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      inst_p1     <= NOP_INST;
      pc_plus4_p1 <= '0;
      vld_p1      <= 1'b0;
    end else if (redirect_en) begin
      inst_p1     <= NOP_INST;
      pc_plus4_p1 <= '0;
      vld_p1      <= 1'b0;
    end else if (!stall) begin
      inst_p1     <= imem_data;
      pc_plus4_p1 <= pc_plus4_p0;
      vld_p1      <= 1'b1;
    end
  end

  assign pc_out      = pc_p0;
  assign if_inst     = inst_p1;
  assign if_pc_plus4 = pc_plus4_p1;
  assign if_valid    = vld_p1;

`ifdef FETCH_PERF_CNT_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      fetch_count <= '0;
      stall_count <= '0;
    end else if (!redirect_en) begin
      if (stall) stall_count <= stall_count + 32'd1;
      else       fetch_count <= fetch_count + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: vector table plus hand-written reset sequence.
module tb_fetch_stage;

  logic        clk;
  logic        reset;
  logic        stall;
  logic        redirect_en;
  logic [31:0] redirect_pc;
  logic [31:0] imem_data;
  logic [10:0] imem_addr;
  logic [31:0] pc_out;
  logic [31:0] if_inst;
  logic [31:0] if_pc_plus4;
  logic        if_valid;
`ifdef FETCH_PERF_CNT_EN
  logic [31:0] fetch_count;
  logic [31:0] stall_count;
`endif

  int checks = 0;
  int errors = 0;

  fetch_stage dut (
    .clk         (clk),
    .reset       (reset),
    .stall       (stall),
    .redirect_en (redirect_en),
    .redirect_pc (redirect_pc),
    .imem_data   (imem_data),
    .imem_addr   (imem_addr),
    .pc_out      (pc_out),
    .if_inst     (if_inst),
    .if_pc_plus4 (if_pc_plus4),
    .if_valid    (if_valid)
`ifdef FETCH_PERF_CNT_EN
    ,
    .fetch_count (fetch_count),
    .stall_count (stall_count)
`endif
  );

  // Address-tagged instruction memory
  assign imem_data = 32'hA000_0000 | {21'd0, imem_addr};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        stall;
    logic        redir;
    logic [31:0] rpc;
    logic [31:0] pc;
    logic [31:0] inst;
    logic [31:0] pp4;
    logic        vld;
    logic [10:0] addr;
  } vec_t;

  vec_t vecs[14];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_reset_state(input string tag);
    chk({tag, "_pc"},    pc_out,             32'h0);
    chk({tag, "_inst"},  if_inst,            32'h0);
    chk({tag, "_pp4"},   if_pc_plus4,        32'h0);
    chk({tag, "_vld"},   {31'd0, if_valid},  32'h0);
    chk({tag, "_addr"},  {21'd0, imem_addr}, 32'h0);
  endtask

  initial begin
`ifdef FETCH_PERF_CNT_EN
    int nf = 0;
    int ns = 0;
`endif
    //           stall redir rpc           pc            inst          pp4           vld  addr
    vecs[0]  = '{1'b0, 1'b0, 32'h0,        32'h4,        32'hA0000000, 32'h4,        1'b1, 11'h001};
    vecs[1]  = '{1'b0, 1'b0, 32'h0,        32'h8,        32'hA0000001, 32'h8,        1'b1, 11'h002};
    vecs[2]  = '{1'b1, 1'b0, 32'h0,        32'h8,        32'hA0000001, 32'h8,        1'b1, 11'h002};
    vecs[3]  = '{1'b1, 1'b0, 32'h0,        32'h8,        32'hA0000001, 32'h8,        1'b1, 11'h002};
    vecs[4]  = '{1'b1, 1'b0, 32'h0,        32'h8,        32'hA0000001, 32'h8,        1'b1, 11'h002};
    vecs[5]  = '{1'b0, 1'b0, 32'h0,        32'hC,        32'hA0000002, 32'hC,        1'b1, 11'h003};
    vecs[6]  = '{1'b0, 1'b1, 32'h40,       32'h40,       32'h0,        32'h0,        1'b0, 11'h010};
    vecs[7]  = '{1'b0, 1'b0, 32'h0,        32'h44,       32'hA0000010, 32'h44,       1'b1, 11'h011};
    vecs[8]  = '{1'b1, 1'b1, 32'h23,       32'h20,       32'h0,        32'h0,        1'b0, 11'h008};
    vecs[9]  = '{1'b1, 1'b0, 32'h0,        32'h20,       32'h0,        32'h0,        1'b0, 11'h008};
    vecs[10] = '{1'b0, 1'b0, 32'h0,        32'h24,       32'hA0000008, 32'h24,       1'b1, 11'h009};
    vecs[11] = '{1'b0, 1'b1, 32'hFFFFFFFC, 32'hFFFFFFFC, 32'h0,        32'h0,        1'b0, 11'h7FF};
    vecs[12] = '{1'b0, 1'b0, 32'h0,        32'h0,        32'hA00007FF, 32'h0,        1'b1, 11'h000};
    vecs[13] = '{1'b0, 1'b0, 32'h0,        32'h4,        32'hA0000000, 32'h4,        1'b1, 11'h001};

    reset       = 1'b0;
    stall       = 1'b0;
    redirect_en = 1'b0;
    redirect_pc = 32'h0;
    #12;
    chk_reset_state("reset_hold");
    reset = 1'b1;
    #1;
    chk_reset_state("reset_release");
`ifdef FETCH_PERF_CNT_EN
    chk("fetch_cnt_init", fetch_count, 32'd0);
    chk("stall_cnt_init", stall_count, 32'd0);
`endif

    for (int i = 0; i < 14; i++) begin
      stall       = vecs[i].stall;
      redirect_en = vecs[i].redir;
      redirect_pc = vecs[i].rpc;
`ifdef FETCH_PERF_CNT_EN
      if (!vecs[i].redir) begin
        if (vecs[i].stall) ns++;
        else               nf++;
      end
`endif
      step();
      chk($sformatf("v%0d_pc", i),   pc_out,             vecs[i].pc);
      chk($sformatf("v%0d_inst", i), if_inst,            vecs[i].inst);
      chk($sformatf("v%0d_pp4", i),  if_pc_plus4,        vecs[i].pp4);
      chk($sformatf("v%0d_vld", i),  {31'd0, if_valid},  {31'd0, vecs[i].vld});
      chk($sformatf("v%0d_addr", i), {21'd0, imem_addr}, {21'd0, vecs[i].addr});
    end
`ifdef FETCH_PERF_CNT_EN
    chk("fetch_cnt_table", fetch_count, nf);
    chk("stall_cnt_table", stall_count, ns);
`endif

    // Redirect to 0x30, stall there, then drop reset between clock edges
    stall       = 1'b0;
    redirect_en = 1'b1;
    redirect_pc = 32'h30;
    step();
    redirect_en = 1'b0;
    stall       = 1'b1;
    step();
    chk("stall30_pc", pc_out, 32'h30);
    #2;
    reset = 1'b0;
    #1;
    chk_reset_state("async_reset");
`ifdef FETCH_PERF_CNT_EN
    chk("fetch_cnt_rst", fetch_count, 32'd0);
    chk("stall_cnt_rst", stall_count, 32'd0);
`endif
    stall = 1'b0;
    step();
    chk_reset_state("reset_edge");
    reset = 1'b1;
    step();
    chk("post_rst_pc",   pc_out,            32'h4);
    chk("post_rst_inst", if_inst,           32'hA0000000);
    chk("post_rst_vld",  {31'd0, if_valid}, 32'h1);
    step();
    stall = 1'b1;
    step();
    redirect_en = 1'b1;
    redirect_pc = 32'h100;
    step();
    redirect_en = 1'b0;
    stall       = 1'b0;
    chk("post_rst_redir_pc", pc_out, 32'h100);
`ifdef FETCH_PERF_CNT_EN
    chk("fetch_cnt_final", fetch_count, 32'd2);
    chk("stall_cnt_final", stall_count, 32'd1);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
